pipe_stage_skid_reg: RTL and testbench

PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

---
 rtl/pipe_stage_skid_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry pipeline stage register with a skid buffer. in_ready is taken only
// from registered state, so the upstream ready path never sees out_ready.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [ADDR_W-1:0] out_dest,
  output logic [1:0]        count
);

  localparam int ENTRY_W = CTRL_W + 2 * DATA_W + ADDR_W;

  // Encodings equal the occupancy so count comes straight from the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [ENTRY_W-1:0] main_reg, skid_reg;
  logic [ENTRY_W-1:0] in_entry;
  logic               load_main_in, load_main_skid, load_skid;
  logic               push, pop;
  logic [CTRL_W-1:0]  main_ctrl;

  assign in_entry  = {in_ctrl, in_alu_res, in_val_rm, in_dest};
  assign in_ready  = (state_reg != FULL) & ~rst;
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = state_reg;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Entries are written only on load strobes; flush just drops occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main_in) begin
        main_reg <= in_entry;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= in_entry;
      end
    end
  end

  assign main_ctrl   = main_reg[ENTRY_W-1 -: CTRL_W];
  assign out_alu_res = main_reg[2*DATA_W+ADDR_W-1 -: DATA_W];
  assign out_val_rm  = main_reg[DATA_W+ADDR_W-1 -: DATA_W];
  assign out_dest    = main_reg[ADDR_W-1:0];

  // A bubble must never carry write-back or memory enables.
  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
      assign out_ctrl[gi] = main_ctrl[gi] & out_valid;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: directed scenarios followed by
// randomized traffic, checked against a queue-based occupancy model.
module tb_pipe_stage_skid_reg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int CTRL_W  = 3;
  localparam int ENTRY_W = CTRL_W + 2 * DATA_W + ADDR_W;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu_res;
  logic [DATA_W-1:0] in_val_rm;
  logic [ADDR_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_val_rm;
  logic [ADDR_W-1:0] out_dest;
  logic [1:0]        count;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu_res(in_alu_res), .in_val_rm(in_val_rm), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_alu_res(out_alu_res), .out_val_rm(out_val_rm), .out_dest(out_dest),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [ENTRY_W-1:0] exp_q[$];
  int occ = 0;
  bit rst_seen = 1'b0;

  function automatic logic [ENTRY_W-1:0] mk(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] r, input logic [ADDR_W-1:0] d);
    return {c, a, r, d};
  endfunction

  task automatic check(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; the model updates at the sampling edge.
  task automatic cyc(input bit v, input bit r, input bit fl, input bit rs, input logic [ENTRY_W-1:0] e);
    bit push;
    bit pop;
    in_valid  = v;
    out_ready = r;
    flush     = fl;
    rst       = rs;
    {in_ctrl, in_alu_res, in_val_rm, in_dest} = e;
    @(posedge clk);
    push     = v && (occ < 2) && !rs;
    pop      = (occ > 0) && r;
    rst_seen = rs;
    if (rs || fl) begin
      occ = 0;
      exp_q.delete();
    end else begin
      occ = occ + (push ? 1 : 0) - (pop ? 1 : 0);
      if (push) exp_q.push_back(e);
    end
    #1;
  endtask

  // Monitor: compares DUT outputs against the scoreboard away from the clock edge.
  initial begin
    bit                 prev_hold;
    logic [ENTRY_W-1:0] prev_out;
    logic [ENTRY_W-1:0] cur_out;
    logic [ENTRY_W-1:0] exp;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      cur_out = {out_ctrl, out_alu_res, out_val_rm, out_dest};
      check("count", ENTRY_W'(count), ENTRY_W'(exp_q.size()));
      check("out_valid", ENTRY_W'(out_valid), ENTRY_W'(exp_q.size() != 0));
      check("in_ready", ENTRY_W'(in_ready), ENTRY_W'((exp_q.size() < 2) && !rst));
      if (!out_valid) check("bubble_ctrl", ENTRY_W'(out_ctrl), '0);
      if (rst_seen) check("reset_outs", cur_out, '0);
      if (prev_hold) check("hold_stable", cur_out, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %h expected no entry at %0t", cur_out, $time);
        end else begin
          exp = exp_q.pop_front();
          check("data_order", cur_out, exp);
          $display("pop ctrl=%h alu=%h rm=%h dest=%h at %0t", out_ctrl, out_alu_res, out_val_rm, out_dest, $time);
        end
      end
      prev_hold = out_valid && !out_ready && !rst && !flush;
      prev_out  = cur_out;
    end
  end

  initial begin
    logic [ENTRY_W-1:0] ea, eb, ec, z;
    int rdy_pct;
    z  = '0;
    ea = mk(3'b101, 32'hA0A0_0001, 32'h1111_0000, 4'd5);
    eb = mk(3'b011, 32'hB0B0_0002, 32'h2222_0000, 4'd9);
    ec = mk(3'b111, 32'hC0C0_0003, 32'h3333_0000, 4'd12);

    cyc(0, 0, 0, 1, z);
    cyc(0, 0, 0, 1, z);
    cyc(0, 1, 0, 0, z);

    // Single push then drain to EMPTY.
    cyc(1, 1, 0, 0, mk(3'b001, 32'h0000_00AA, 32'h0, 4'd3));
    cyc(0, 1, 0, 0, z);
    cyc(0, 1, 0, 0, z);

    // Back-to-back stream at full throughput.
    for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 0, mk(3'b001, DATA_W'(i), DATA_W'(i * 16), ADDR_W'(i)));
    cyc(0, 1, 0, 0, z);
    cyc(0, 1, 0, 0, z);

    // Backpressure fills the skid, then drains in order.
    cyc(1, 0, 0, 0, ea);
    cyc(1, 0, 0, 0, eb);
    cyc(1, 0, 0, 0, ec);
    cyc(0, 0, 0, 0, z);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, z);

    // Flush while full with a concurrent push.
    cyc(1, 0, 0, 0, ea);
    cyc(1, 0, 0, 0, eb);
    cyc(1, 0, 1, 0, ec);
    cyc(0, 1, 0, 0, z);
    cyc(0, 1, 0, 0, z);

    // Reset while full.
    cyc(1, 0, 0, 0, ea);
    cyc(1, 0, 0, 0, eb);
    cyc(0, 0, 0, 1, z);
    cyc(0, 1, 0, 0, z);
    cyc(1, 1, 0, 0, ec);
    cyc(0, 1, 0, 0, z);

    // Randomized traffic with varying backpressure.
    rdy_pct = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) rdy_pct = int'($urandom_range(10, 95));
      cyc($urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < rdy_pct,
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 299) == 0,
          mk(CTRL_W'($urandom), $urandom, $urandom, ADDR_W'($urandom)));
    end

    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, z);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
